// File: rtl/cpu_run_ctrl_if.sv
// ============================================================================
// Module      : cpu_run_ctrl_if
// Description : Bundles the button, burst, breakpoint and status signals that
//               pass between the run controller and the board/core side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_run_ctrl_if #(
    parameter int CNT_W = 16,
    parameter int XLEN  = 32
);
    logic             btn_run;
    logic             btn_step;
    logic             btn_halt;
    logic [CNT_W-1:0] nsteps;
    logic             bp_en;
    logic [XLEN-1:0]  bp_addr;
    logic [XLEN-1:0]  pc;
    logic             cpu_en;
    logic             halted;
    logic             bp_hit;
    logic [1:0]       state;
    logic [31:0]      retired;

    // The controller receives the board and core inputs and drives status.
    modport slave (
        input  btn_run, btn_step, btn_halt, nsteps, bp_en, bp_addr, pc,
        output cpu_en, halted, bp_hit, state, retired
    );

    modport master (
        output btn_run, btn_step, btn_halt, nsteps, bp_en, bp_addr, pc,
        input  cpu_en, halted, bp_hit, state, retired
    );
endinterface

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
// ============================================================================
// Module      : cpu_run_ctrl
// Description : Run/halt/single-step/burst controller with PC breakpoint and
//               retired-instruction counter, producing the core clock enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_run_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 16,
    parameter int XLEN       = 32
) (
    input  wire logic      clk_out,
    input  wire logic      rst,
    cpu_run_ctrl_if.slave  bus
);

    localparam int DCW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        BURST = 2'd3
    } state_t;

    // Button order in the vectors: [2]=halt, [1]=step, [0]=run
    logic [2:0] btn_raw;
    logic [2:0] press;

    assign btn_raw = {bus.btn_halt, bus.btn_step, bus.btn_run};

    generate
        for (genvar i = 0; i < 3; i++) begin : g_btn
            logic           sync1;
            logic           sync2;
            logic           level;
            logic           pulse;
            logic [DCW-1:0] deb_cnt;

            // Pulse is raised on the same edge the debounced level rises,
            // so a press costs 2 sync + DEB_CYCLES edges before it is visible.
            always_ff @(posedge clk_out or negedge rst) begin
                if (!rst) begin
                    sync1   <= 1'b0;
                    sync2   <= 1'b0;
                    level   <= 1'b0;
                    pulse   <= 1'b0;
                    deb_cnt <= '0;
                end else begin
                    sync1 <= btn_raw[i];
                    sync2 <= sync1;
                    pulse <= 1'b0;
                    if (sync2 == level) begin
                        deb_cnt <= '0;
                    end else if (deb_cnt == DCW'(DEB_CYCLES - 1)) begin
                        level   <= sync2;
                        pulse   <= sync2;
                        deb_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
            end

            assign press[i] = pulse;
        end
    endgenerate

    logic halt_p;
    logic step_p;
    logic run_p;

    assign halt_p = press[2];
    assign step_p = press[1];
    assign run_p  = press[0];

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             first_q;
    logic             first_d;
    logic             bp_hit_q;
    logic             bp_hit_d;
    logic [31:0]      retired_q;
    logic             bp_stop;
    logic             cpu_en;

    // The first cycle after leaving HALT masks the compare so a resume from
    // the breakpoint PC executes that instruction.
    assign bp_stop = bus.bp_en && (bus.pc == bus.bp_addr) &&
                     ((state_q == RUN) || (state_q == BURST)) && !first_q;
    assign cpu_en  = (state_q != HALT) && !bp_stop;

    always_ff @(posedge clk_out or negedge rst) begin
        if (!rst) begin
            state_q  <= HALT;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            bp_hit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            bp_hit_q <= bp_hit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        first_d  = 1'b0;
        bp_hit_d = bp_hit_q;
        case (state_q)
            HALT: begin
                if (halt_p) begin
                    state_d = HALT;
                end else if (step_p) begin
                    state_d  = STEP;
                    first_d  = 1'b1;
                    bp_hit_d = 1'b0;
                end else if (run_p) begin
                    first_d  = 1'b1;
                    bp_hit_d = 1'b0;
                    if (bus.nsteps == '0) begin
                        state_d = RUN;
                    end else begin
                        state_d = BURST;
                        cnt_d   = bus.nsteps;
                    end
                end
            end
            STEP: begin
                state_d = HALT;
            end
            RUN: begin
                if (halt_p) begin
                    state_d = HALT;
                end else if (bp_stop) begin
                    state_d  = HALT;
                    bp_hit_d = 1'b1;
                end
            end
            BURST: begin
                if (halt_p) begin
                    state_d = HALT;
                end else if (bp_stop) begin
                    state_d  = HALT;
                    bp_hit_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = HALT;
                    end
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge clk_out or negedge rst) begin
        if (!rst) begin
            retired_q <= '0;
        end else if (cpu_en) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign bus.cpu_en  = cpu_en;
    assign bus.halted  = (state_q == HALT);
    assign bus.bp_hit  = bp_hit_q;
    assign bus.state   = state_q;
    assign bus.retired = retired_q;

endmodule

`default_nettype wire
